sram_bridge: RTL and testbench
==============================

// Module: sram_bridge
// PURPOSE
//  Parametrised CPU-to-memory bridge; next generation of the Retro16 memory controller.
//  Accepts one word request at a time over a valid/ready handshake.
//  Routes each request by address: external narrow async SRAM (multi-beat), video RAM write port, or keyboard read port.
//  Sits between the CPU bus and the board SRAM and peripheral RAMs.
// PARAMETERS
//  ADDR_W      16        CPU word-address width
//  DATA_W      16        CPU data width
//  SRAM_DW     8         SRAM data width; BEATS=DATA_W/SRAM_DW, integer >=1
//  SRAM_AW     21        SRAM address width; must be >= ADDR_W+clog2(BEATS)
//  IO_BASE     16'hC000  addresses >= IO_BASE are I/O, below are SRAM
//  VRAM_BASE   16'hF82F  I/O addresses >= VRAM_BASE map to video RAM
//  VRAM_AW     12        video RAM address width
//  KBD_ADDR    16'hC000  I/O address returning kbd_ram_data
//  WAIT_CYCLES 1         extra strobe-active cycles per SRAM beat (0..15)
// PORTS
//  clk            in    1          system clock, rising edge
//  rst_n          in    1          async active-low reset
//  req_valid      in    1          request present
//  req_ready      out   1          bridge can accept (high only in IDLE)
//  req_we         in    1          1=write, 0=read
//  req_addr       in    ADDR_W     word address
//  req_wdata      in    DATA_W     write data
//  rsp_valid      out   1          1-cycle pulse, read data valid (reads only)
//  rsp_rdata      out   DATA_W     read data, held until next rsp_valid
//  sram_addr      out   SRAM_AW    {zero pad, addr, beat index}
//  sram_data      inout SRAM_DW    SRAM data bus
//  sram_ce_n      out   1          chip enable, active low
//  sram_oe_n      out   1          output enable, active low
//  sram_we_n      out   1          write enable, active low
//  video_ram_addr out   VRAM_AW    req_addr-VRAM_BASE, truncated to VRAM_AW
//  video_ram_data out   DATA_W     video write data
//  video_ram_we   out   1          1-cycle write strobe
//  kbd_ram_addr   out   16         keyboard RAM address, always 0
//  kbd_ram_data   in    16         keyboard word
// BEHAVIOUR
//  Reset (async, mid-operation too): FSM->IDLE; ce_n/oe_n/we_n=1; sram_data Hi-Z; req_ready=1;
//   rsp_valid=0, rsp_rdata=0, sram_addr=0, video_ram_*=0, kbd_ram_addr=0. Any in-flight access is dropped.
//  Handshake: accept on req_valid&&req_ready; addr/we/wdata latched at accept, need not be held.
//   rsp_valid has no backpressure.
//  FSM: IDLE -> STROBE -> RECOVER -> (STROBE next beat | IDLE).
//  IDLE, I/O read: no state change; next cycle rsp_valid=1,
//   rsp_rdata=kbd_ram_data if addr==KBD_ADDR, else 0.
//  IDLE, I/O write: addr>=VRAM_BASE -> next cycle video_ram_we=1 for exactly 1 cycle with addr/data;
//   otherwise write dropped silently.
//  IDLE, SRAM access: beat=0 -> STROBE.
//  STROBE: ce_n=0; read: oe_n=0; write: we_n=0 and sram_data driven.
//   Lasts WAIT_CYCLES+1 cycles (counter); read byte sampled on last STROBE cycle.
//  RECOVER: 1 cycle; oe_n=we_n=1, ce_n=0, sram_addr and write data held (hold time).
//   Then beat++ -> STROBE, or after last beat ce_n=1 -> IDLE.
//  Byte order: big-endian both directions; beat 0 = data[DATA_W-1 -: SRAM_DW].
//  Latency accept->rsp_valid: BEATS*(WAIT_CYCLES+2) cycles.
//   Writes: same occupancy, no rsp. req_ready low throughout.
//  sram_data driven only in write STROBE/RECOVER, never while oe_n=0.
//  BEATS==1: sram_addr has no beat bits.
// CONFIGURATION
//  MEMCTL_RDCACHE_EN defined: one-entry read cache (tag, data, valid).
//   - SRAM read hit: rsp_valid next cycle, no SRAM strobes.
//   - Completed SRAM read fills the entry.
//   - SRAM write to the tagged address updates the cached data (write-through).
//   - Reset clears valid.
//  Not defined: every SRAM read accesses SRAM; no cache registers exist.
// TESTING
//  1. Reset, write 16'hBEEF to 0x0010, WAIT_CYCLES=1 -> SRAM addr 0x20 gets BE, 0x21 gets EF;
//     we_n low 2 cycles per beat; busy 6 cycles.
//  2. Read 0x0010 -> rsp_valid 6 cycles after accept, rsp_rdata=16'hBEEF; sram_data never driven while oe_n=0.
//  3. Write 16'h1234 to 0xF830 -> video_ram_we pulse 1 cycle, addr=12'h001, data=16'h1234;
//     write to 0xC005 -> no strobes.
//  4. kbd_ram_data=16'h0041, read 0xC000 -> rsp_valid next cycle, rsp_rdata=16'h0041; read 0xC001 -> 16'h0000.
//  5. Assert rst_n=0 during beat 1 of a write -> all strobes high and bus Hi-Z immediately; req_ready=1 after release.
//  6. MEMCTL_RDCACHE_EN: read 0x0010 twice -> second rsp 1 cycle, no ce_n activity;
//     write 16'h5555 to 0x0010, reread -> 16'h5555.

Source files
------------

// File: rtl/sram_bridge.sv
// sram_bridge: CPU word-request bridge to a narrow asynchronous SRAM (multi-beat,
// big-endian), a video RAM write port and a keyboard read port.
// Build option: define MEMCTL_RDCACHE_EN to add a one-entry read cache.
module sram_bridge #(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       SRAM_DW     = 8,
    parameter int unsigned       SRAM_AW     = 21,
    parameter logic [ADDR_W-1:0] IO_BASE     = 16'hC000,
    parameter logic [ADDR_W-1:0] VRAM_BASE   = 16'hF82F,
    parameter int unsigned       VRAM_AW     = 12,
    parameter logic [ADDR_W-1:0] KBD_ADDR    = 16'hC000,
    parameter int unsigned       WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               rsp_valid,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  logic [SRAM_DW-1:0] sram_data,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [VRAM_AW-1:0] video_ram_addr,
    output logic [DATA_W-1:0]  video_ram_data,
    output logic               video_ram_we,
    output logic [15:0]        kbd_ram_addr,
    input  logic [15:0]        kbd_ram_data
);

    localparam int unsigned BEATS     = DATA_W / SRAM_DW;
    localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [3:0]        WAIT_LAST = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, STROBE, RECOVER} state_t;

    state_t                          state, state_nxt;
    logic [3:0]                      wait_cnt;
    logic [BEAT_W-1:0]               beat;
    logic [BEAT_W-1:0]               slot;
    logic [ADDR_W-1:0]               addr_q;
    logic                            we_q;
    logic [BEATS-1:0][SRAM_DW-1:0]   wdata_q;
    logic [BEATS-1:0][SRAM_DW-1:0]   rd_buf;
    logic [BEATS-1:0][SRAM_DW-1:0]   rd_next;
    logic [SRAM_DW-1:0]              sram_dout;
    logic                            sram_drive;
    logic [SRAM_AW-1:0]              sram_addr_act;
    logic [VRAM_AW-1:0]              vram_off;
    logic                            accept;
    logic                            is_io;
    logic                            strobe_last;
    logic                            beat_last;
    logic                            cache_hit;
    logic                            rd_hit;
    logic [DATA_W-1:0]               cache_rdata;

    assign accept      = req_valid && req_ready;
    assign is_io       = (req_addr >= IO_BASE);
    assign strobe_last = (state == STROBE) && (wait_cnt == WAIT_LAST);
    assign beat_last   = (beat == LAST_BEAT);
    assign rd_hit      = accept && !req_we && !is_io && cache_hit;
    assign vram_off    = VRAM_AW'(req_addr - VRAM_BASE);
    assign kbd_ram_addr = '0;

    // Beat 0 carries the most significant byte, so beat b lives in slot BEATS-1-b.
    assign slot      = LAST_BEAT - beat;
    assign sram_dout = wdata_q[slot];
    assign sram_data = sram_drive ? sram_dout : 'z;

    generate
        if (BEATS > 1) begin : g_beat_bits
            assign sram_addr_act = SRAM_AW'({addr_q, beat});
        end else begin : g_no_beat_bits
            assign sram_addr_act = SRAM_AW'(addr_q);
        end
    endgenerate

    // Read word with the byte on the bus merged into the current beat slot
    always_comb begin
        rd_next       = rd_buf;
        rd_next[slot] = sram_data;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: I/O requests and cache hits complete without leaving IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !is_io && !rd_hit) state_nxt = STROBE;
            STROBE:  if (wait_cnt == WAIT_LAST) state_nxt = RECOVER;
            RECOVER: state_nxt = beat_last ? IDLE : STROBE;
            default: state_nxt = IDLE;
        endcase
    end

    // SRAM strobes and bus control decoded from the current state
    always_comb begin
        req_ready  = (state == IDLE);
        sram_ce_n  = (state == IDLE);
        sram_oe_n  = !((state == STROBE) && !we_q);
        sram_we_n  = !((state == STROBE) && we_q);
        sram_drive = (state != IDLE) && we_q;
        sram_addr  = (state == IDLE) ? '0 : sram_addr_act;
    end

    // Request capture, beat/wait counters, read assembly, responses and video port.
    // The response is registered on the edge that closes the last strobe so that it
    // is visible during the final recovery cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt       <= '0;
            beat           <= '0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            rd_buf         <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            video_ram_we   <= 1'b0;
            video_ram_addr <= '0;
            video_ram_data <= '0;
        end else begin
            rsp_valid    <= 1'b0;
            video_ram_we <= 1'b0;
            if (accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
                if (is_io) begin
                    if (!req_we) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= (req_addr == KBD_ADDR) ? DATA_W'(kbd_ram_data) : '0;
                    end else if (req_addr >= VRAM_BASE) begin
                        video_ram_we   <= 1'b1;
                        video_ram_addr <= vram_off;
                        video_ram_data <= req_wdata;
                    end
                end else if (rd_hit) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= cache_rdata;
                end
            end
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    beat     <= '0;
                end
                STROBE: begin
                    if (strobe_last) begin
                        wait_cnt <= '0;
                        if (!we_q) begin
                            rd_buf <= rd_next;
                            if (beat_last) begin
                                rsp_valid <= 1'b1;
                                rsp_rdata <= rd_next;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RECOVER: beat <= beat_last ? '0 : beat + BEAT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef MEMCTL_RDCACHE_EN
    logic              cache_valid;
    logic [ADDR_W-1:0] cache_tag;
    logic [DATA_W-1:0] cache_data;

    assign cache_hit   = cache_valid && (cache_tag == req_addr);
    assign cache_rdata = cache_data;

    // One-entry read cache: filled by completed SRAM reads, updated by writes to the tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
        end else if (strobe_last && !we_q && beat_last) begin
            cache_valid <= 1'b1;
            cache_tag   <= addr_q;
            cache_data  <= rd_next;
        end else if (accept && req_we && !is_io && cache_hit) begin
            cache_data  <= req_wdata;
        end
    end
`else
    assign cache_hit   = 1'b0;
    assign cache_rdata = '0;
`endif

endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: directed table-driven bench for sram_bridge with a byte SRAM model.
// Build option: MEMCTL_RDCACHE_EN selects the cached expectations for the reread rows.
module tb_sram_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [20:0] sram_addr;
    wire  [7:0]  sram_data;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [11:0] video_ram_addr;
    logic [15:0] video_ram_data;
    logic        video_ram_we;
    logic [15:0] kbd_ram_addr;
    logic [15:0] kbd_ram_data;

    int n_checks = 0;
    int n_fail   = 0;

    sram_bridge #(
        .ADDR_W(16), .DATA_W(16), .SRAM_DW(8), .SRAM_AW(21),
        .IO_BASE(16'hC000), .VRAM_BASE(16'hF82F), .VRAM_AW(12),
        .KBD_ADDR(16'hC000), .WAIT_CYCLES(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .video_ram_addr(video_ram_addr), .video_ram_data(video_ram_data),
        .video_ram_we(video_ram_we),
        .kbd_ram_addr(kbd_ram_addr), .kbd_ram_data(kbd_ram_data)
    );

    always #5 clk = ~clk;

    // Asynchronous byte SRAM: drives the bus while selected and output-enabled
    logic [7:0] mem [0:2047];
    assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[10:0]] : 8'hzz;

    // Bus monitor: running strobe/pulse totals, first address per access, bus fights
    int          tot_we = 0, tot_oe = 0, tot_ce = 0, tot_vwe = 0, conflicts = 0;
    logic [11:0] last_vaddr = '0;
    logic [15:0] last_vdata = '0;
    logic [20:0] sa_first   = '0;
    logic        prev_ce_n  = 1'b1;
    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) mem[sram_addr[10:0]] <= sram_data;
        if (!sram_we_n) tot_we++;
        if (!sram_oe_n) tot_oe++;
        if (!sram_ce_n) tot_ce++;
        if (video_ram_we) begin
            tot_vwe++;
            last_vaddr = video_ram_addr;
            last_vdata = video_ram_data;
        end
        if (!sram_ce_n && prev_ce_n) sa_first = sram_addr;
        prev_ce_n = sram_ce_n;
        if (!sram_oe_n && (sram_data !== mem[sram_addr[10:0]])) conflicts++;
    end

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] kbd;
        logic        exp_rsp;
        logic [15:0] exp_rdata;
        int          exp_lat;
        int          exp_busy;
        int          exp_we;
        int          exp_oe;
        int          exp_ce;
        int          exp_vwe;
        logic [11:0] exp_vaddr;
        logic [15:0] exp_vdata;
        logic [20:0] exp_sa;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                                input logic [15:0] kbd, input logic rsp, input logic [15:0] rdata,
                                input int lat, input int busy, input int nwe, input int noe,
                                input int nce, input int nvwe, input logic [11:0] vaddr,
                                input logic [15:0] vdata, input logic [20:0] sa);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.kbd = kbd;
        v.exp_rsp = rsp; v.exp_rdata = rdata; v.exp_lat = lat; v.exp_busy = busy;
        v.exp_we = nwe; v.exp_oe = noe; v.exp_ce = nce; v.exp_vwe = nvwe;
        v.exp_vaddr = vaddr; v.exp_vdata = vdata; v.exp_sa = sa;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request: drive for one cycle, then watch for response and return of ready
    task automatic apply(input vec_t v, input string tag);
        int   s_we, s_oe, s_ce, s_vwe, lat, busy;
        logic got;
        logic [15:0] rdat;
        @(negedge clk);
        #1;
        check({tag, "_ready_in"}, {31'd0, req_ready}, 32'd1);
        s_we = tot_we; s_oe = tot_oe; s_ce = tot_ce; s_vwe = tot_vwe;
        kbd_ram_data = v.kbd;
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        got = 1'b0; lat = -1; busy = -1; rdat = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0; req_addr = 16'h0BAD; req_wdata = 16'h0000;
            end
            if (rsp_valid && !got) begin
                got = 1'b1; lat = k; rdat = rsp_rdata;
            end
            if (req_ready) begin
                busy = k - 1;
                break;
            end
        end
        @(negedge clk);
        #1;
        check({tag, "_rsp"}, {31'd0, got}, {31'd0, v.exp_rsp});
        if (v.exp_rsp) begin
            check({tag, "_rdata"}, {16'd0, rdat}, {16'd0, v.exp_rdata});
            check({tag, "_lat"}, lat, v.exp_lat);
        end
        check({tag, "_busy"}, busy, v.exp_busy);
        check({tag, "_we_cyc"}, tot_we - s_we, v.exp_we);
        check({tag, "_oe_cyc"}, tot_oe - s_oe, v.exp_oe);
        check({tag, "_ce_cyc"}, tot_ce - s_ce, v.exp_ce);
        check({tag, "_vwe_cyc"}, tot_vwe - s_vwe, v.exp_vwe);
        if (v.exp_vwe > 0) begin
            check({tag, "_vaddr"}, {20'd0, last_vaddr}, {20'd0, v.exp_vaddr});
            check({tag, "_vdata"}, {16'd0, last_vdata}, {16'd0, v.exp_vdata});
        end
        if (v.exp_ce > 0) check({tag, "_sram_addr"}, {11'd0, sa_first}, {11'd0, v.exp_sa});
    endtask

    vec_t vecs[$];
    vec_t vecs2[$];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end of the test");
        $fatal(1);
    end

    initial begin
        bit found;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        kbd_ram_data = 16'h0000;

        //            we    addr      wdata     kbd      rsp  rdata    lat busy we oe ce vwe vaddr   vdata     sram_addr
        vecs.push_back(mk(1, 16'h0010, 16'hBEEF, 16'h0000, 0, 16'h0000, 0, 6, 4, 0, 6, 0, 12'h000, 16'h0000, 21'h00020));
        vecs.push_back(mk(0, 16'h0010, 16'hFFFF, 16'h0000, 1, 16'hBEEF, 6, 6, 0, 4, 6, 0, 12'h000, 16'h0000, 21'h00020));
        vecs.push_back(mk(1, 16'h0011, 16'hA55A, 16'h0000, 0, 16'h0000, 0, 6, 4, 0, 6, 0, 12'h000, 16'h0000, 21'h00022));
        vecs.push_back(mk(0, 16'h0011, 16'hFFFF, 16'h0000, 1, 16'hA55A, 6, 6, 0, 4, 6, 0, 12'h000, 16'h0000, 21'h00022));
        vecs.push_back(mk(1, 16'hBFFF, 16'h0102, 16'h0000, 0, 16'h0000, 0, 6, 4, 0, 6, 0, 12'h000, 16'h0000, 21'h17FFE));
        vecs.push_back(mk(0, 16'hBFFF, 16'hFFFF, 16'h0000, 1, 16'h0102, 6, 6, 0, 4, 6, 0, 12'h000, 16'h0000, 21'h17FFE));
        vecs.push_back(mk(1, 16'hF830, 16'h1234, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 12'h001, 16'h1234, 21'h0));
        vecs.push_back(mk(1, 16'hC005, 16'hDEAD, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 12'h000, 16'h0000, 21'h0));
        vecs.push_back(mk(1, 16'hF82F, 16'h0F0F, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 12'h000, 16'h0F0F, 21'h0));
        vecs.push_back(mk(1, 16'hF82E, 16'h7777, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 12'h000, 16'h0000, 21'h0));
        vecs.push_back(mk(1, 16'hFFFF, 16'h00FF, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 12'h7D0, 16'h00FF, 21'h0));
        vecs.push_back(mk(0, 16'hC000, 16'hFFFF, 16'h0041, 1, 16'h0041, 1, 0, 0, 0, 0, 0, 12'h000, 16'h0000, 21'h0));
        vecs.push_back(mk(0, 16'hC001, 16'hFFFF, 16'h0041, 1, 16'h0000, 1, 0, 0, 0, 0, 0, 12'h000, 16'h0000, 21'h0));
        vecs.push_back(mk(0, 16'hC005, 16'hFFFF, 16'h1234, 1, 16'h0000, 1, 0, 0, 0, 0, 0, 12'h000, 16'h0000, 21'h0));

`ifdef MEMCTL_RDCACHE_EN
        vecs2.push_back(mk(0, 16'h0010, 16'hFFFF, 16'h0000, 1, 16'hBEEF, 6, 6, 0, 4, 6, 0, 12'h000, 16'h0000, 21'h00020));
        vecs2.push_back(mk(0, 16'h0010, 16'hFFFF, 16'h0000, 1, 16'hBEEF, 1, 0, 0, 0, 0, 0, 12'h000, 16'h0000, 21'h0));
        vecs2.push_back(mk(1, 16'h0010, 16'h5555, 16'h0000, 0, 16'h0000, 0, 6, 4, 0, 6, 0, 12'h000, 16'h0000, 21'h00020));
        vecs2.push_back(mk(0, 16'h0010, 16'hFFFF, 16'h0000, 1, 16'h5555, 1, 0, 0, 0, 0, 0, 12'h000, 16'h0000, 21'h0));
`else
        vecs2.push_back(mk(0, 16'h0010, 16'hFFFF, 16'h0000, 1, 16'hBEEF, 6, 6, 0, 4, 6, 0, 12'h000, 16'h0000, 21'h00020));
        vecs2.push_back(mk(0, 16'h0010, 16'hFFFF, 16'h0000, 1, 16'hBEEF, 6, 6, 0, 4, 6, 0, 12'h000, 16'h0000, 21'h00020));
        vecs2.push_back(mk(1, 16'h0010, 16'h5555, 16'h0000, 0, 16'h0000, 0, 6, 4, 0, 6, 0, 12'h000, 16'h0000, 21'h00020));
        vecs2.push_back(mk(0, 16'h0010, 16'hFFFF, 16'h0000, 1, 16'h5555, 6, 6, 0, 4, 6, 0, 12'h000, 16'h0000, 21'h00020));
`endif

        // Reset values
        #12;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("rst_sram_addr", {11'd0, sram_addr}, 32'd0);
        check("rst_video", {3'd0, video_ram_we, video_ram_addr, video_ram_data}, 32'd0);
        check("rst_kbd_addr", {16'd0, kbd_ram_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

        check("mem_20", {24'd0, mem[11'h020]}, 32'hBE);
        check("mem_21", {24'd0, mem[11'h021]}, 32'hEF);
        check("mem_22", {24'd0, mem[11'h022]}, 32'hA5);
        check("mem_23", {24'd0, mem[11'h023]}, 32'h5A);
        check("mem_7fe", {24'd0, mem[11'h7FE]}, 32'h01);
        check("mem_7ff", {24'd0, mem[11'h7FF]}, 32'h02);

        for (int i = 0; i < vecs2.size(); i++) apply(vecs2[i], $sformatf("c%0d", i));

        // Reset asserted during beat 1 of an SRAM write
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'h7777;
        @(negedge clk);
        req_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!sram_we_n && sram_addr[0]) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midrst_beat1_seen", {31'd0, found}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        check("midrst_bus_released", {31'd0, (sram_data !== 8'h77)}, 32'd1);
        check("midrst_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_sram_addr", {11'd0, sram_addr}, 32'd0);
        check("midrst_rsp", {15'd0, rsp_valid, rsp_rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_ready", {31'd0, req_ready}, 32'd1);
        apply(mk(0, 16'h0011, 16'hFFFF, 16'h0000, 1, 16'hA55A, 6, 6, 0, 4, 6, 0, 12'h000, 16'h0000, 21'h00022), "post0");
        apply(mk(0, 16'hC000, 16'hFFFF, 16'h00C3, 1, 16'h00C3, 1, 0, 0, 0, 0, 0, 12'h000, 16'h0000, 21'h0), "post1");

        check("bus_conflicts", conflicts, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
